muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer for the execute stage. It sits beside the single-cycle ALU, which has no M-extension operations. It accepts one operation on a start pulse, runs a radix-2 shift-add multiply or restoring divide over W_SIZE cycles, and returns a registered result with a one-cycle done pulse. Pipeline control stalls on busy and can abort with kill.

---
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// It uses radix-2 shift-add multiply and restoring divide, one bit per cycle.
// The multiply product and the divide {remainder, quotient} pair share one
// 2*W_SIZE accumulator.
module muldiv_seq #(
    parameter int W_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [W_SIZE-1:0] a,
    input  logic [W_SIZE-1:0] b,
    input  logic              kill,
    output logic              busy,
    output logic              done,
    output logic [W_SIZE-1:0] result
);

    localparam int CW = $clog2(W_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    state_t                state, state_nxt;
    logic [2:0]            op;
    logic [W_SIZE-1:0]     a_reg, b_reg;
    logic [CW-1:0]         counter;
    logic [W_SIZE-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [2*W_SIZE-1:0]   acc;        // {hi, lo} product or {rem, quo}
    logic                  res_neg;    // negate product / quotient
    logic                  rem_neg;    // negate remainder

    // PREP-stage combinational values
    logic                  is_div;
    logic                  a_signed, b_signed, a_neg, b_neg;
    logic [W_SIZE-1:0]     mag_a, mag_b;
    logic                  div_zero, div_ovf, special;
    logic [2*W_SIZE-1:0]   prep_acc;
    logic [W_SIZE-1:0]     prep_opnd;

    // RUN-stage combinational values
    logic [W_SIZE:0]       mul_sum;
    logic [W_SIZE:0]       rem_sh, rem_diff;
    logic [2*W_SIZE-1:0]   step_acc;

    // FIX-stage combinational values
    logic [2*W_SIZE-1:0]   prod_fix;
    logic [W_SIZE-1:0]     quo_fix, rem_fix, res_sel;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; kill only aborts the busy states
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PREP;
            S_PREP: begin
                if (kill)         state_nxt = S_IDLE;
                else if (special) state_nxt = S_FIX;
                else              state_nxt = S_RUN;
            end
            S_RUN: begin
                if (kill)                      state_nxt = S_IDLE;
                else if (counter == {CW{1'b1}}) state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = kill ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
        done = (state == S_DONE);
    end

    // Operand preparation: magnitudes, sign flags and special-case preloads
    always_comb begin
        is_div   = op[2];
        a_signed = (op == F_MULH) || (op == F_MULHSU) || (op == F_DIV) || (op == F_REM);
        b_signed = (op == F_MULH) || (op == F_DIV) || (op == F_REM);
        a_neg    = a_signed && a_reg[W_SIZE-1];
        b_neg    = b_signed && b_reg[W_SIZE-1];
        mag_a    = a_neg ? -a_reg : a_reg;
        mag_b    = b_neg ? -b_reg : b_reg;
        div_zero = is_div && (b_reg == '0);
        div_ovf  = ((op == F_DIV) || (op == F_REM))
                   && (a_reg == {1'b1, {(W_SIZE-1){1'b0}}})
                   && (b_reg == {W_SIZE{1'b1}});
        special  = div_zero || div_ovf;

        if (div_zero)    prep_acc = {a_reg, {W_SIZE{1'b1}}};
        else if (div_ovf) prep_acc = {{W_SIZE{1'b0}}, a_reg};
        else if (is_div) prep_acc = {{W_SIZE{1'b0}}, mag_a};
        else             prep_acc = {{W_SIZE{1'b0}}, mag_b};
        prep_opnd = is_div ? mag_b : mag_a;
    end

    // One multiply or divide iteration
    always_comb begin
        mul_sum  = {1'b0, acc[2*W_SIZE-1:W_SIZE]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc[2*W_SIZE-1:W_SIZE], acc[W_SIZE-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        if (!is_div)
            step_acc = {mul_sum, acc[W_SIZE-1:1]};
        else if (!rem_diff[W_SIZE])
            step_acc = {rem_diff[W_SIZE-1:0], acc[W_SIZE-2:0], 1'b1};
        else
            step_acc = {rem_sh[W_SIZE-1:0], acc[W_SIZE-2:0], 1'b0};
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix = res_neg ? -acc : acc;
        quo_fix  = res_neg ? -acc[W_SIZE-1:0] : acc[W_SIZE-1:0];
        rem_fix  = rem_neg ? -acc[2*W_SIZE-1:W_SIZE] : acc[2*W_SIZE-1:W_SIZE];
        case (op)
            F_MUL:                     res_sel = prod_fix[W_SIZE-1:0];
            F_MULH, F_MULHSU, F_MULHU: res_sel = prod_fix[2*W_SIZE-1:W_SIZE];
            F_DIV, F_DIVU:             res_sel = quo_fix;
            F_REM, F_REMU:             res_sel = rem_fix;
            default:                   res_sel = '0;
        endcase
    end

    // Datapath registers, advanced according to the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            counter <= '0;
            opnd    <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            result  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                S_PREP: begin
                    counter <= '0;
                    opnd    <= prep_opnd;
                    acc     <= prep_acc;
                    // Special results are preloaded already final; no correction.
                    res_neg <= !special && (a_neg ^ b_neg);
                    rem_neg <= !special && a_neg;
                end
                S_RUN: begin
                    counter <= counter + CW'(1);
                    acc     <= step_acc;
                end
                S_FIX: begin
                    if (!kill) result <= res_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a vector table with hand-computed results
// and latencies, plus sequences for the busy, kill and reset corner cases.
module tb_muldiv_seq;

    localparam int W = 32;
    localparam int LAT_NORM = W + 3;   // negedge index of the done cycle, normal
    localparam int LAT_SPEC = 3;       // negedge index of the done cycle, special divide
    localparam int BUSY_NORM = W + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    funct3 = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          kill = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.W_SIZE(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Present one operation and let the start edge go by.
    task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic with_kill);
        @(negedge clk);
        funct3 = f; a = x; b = y; start = 1'b1; kill = with_kill;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
    endtask

    // Wait for done; lat is the index of the negedge (counted from the start
    // edge) at which done is seen. n0 negedges have already been consumed.
    // lat stays 0 if done never arrives within the budget.
    task automatic wait_done(input int n0, output logic [31:0] res, output int lat,
                             output int busy_n);
        lat = 0;
        busy_n = 0;
        for (int n = n0 + 1; n <= n0 + 200; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = result;
    endtask

    // Count done pulses over a number of cycles.
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int lat, busy_n, pulses;

        // MUL / MULH / MULHSU / MULHU
        vecs.push_back('{"mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM});
        vecs.push_back('{"mul_shift",     3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, LAT_NORM});
        vecs.push_back('{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_NORM});
        vecs.push_back('{"mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_NORM});
        vecs.push_back('{"mulh_3_m2",     3'b001, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back('{"mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back('{"mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORM});
        vecs.push_back('{"mulhu_max_2",   3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, LAT_NORM});
        // DIV / DIVU / REM / REMU
        vecs.push_back('{"div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_NORM});
        vecs.push_back('{"rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back('{"div_7_m2",      3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORM});
        vecs.push_back('{"rem_7_m2",      3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT_NORM});
        vecs.push_back('{"div_m7_m2",     3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, LAT_NORM});
        vecs.push_back('{"rem_m7_m2",     3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back('{"div_min_1",     3'b100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, LAT_NORM});
        vecs.push_back('{"divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        LAT_NORM});
        vecs.push_back('{"remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         LAT_NORM});
        vecs.push_back('{"divu_max_1",    3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back('{"remu_max_16",   3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, LAT_NORM});
        // Special divides
        vecs.push_back('{"divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC});
        vecs.push_back('{"rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         LAT_SPEC});
        vecs.push_back('{"div_m1_0",      3'b100, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, LAT_SPEC});
        vecs.push_back('{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC});
        vecs.push_back('{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPEC});

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result,        32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            launch(vecs[i].f, vecs[i].x, vecs[i].y, 1'b0);
            wait_done(0, res, lat, busy_n);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            if (i == 0) check("mul_busy_cycles", busy_n, BUSY_NORM);
            if (vecs[i].lat == LAT_SPEC) check({vecs[i].name, "_busy"}, busy_n, 2);
        end

        // A second start while busy is ignored
        launch(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
        repeat (4) @(negedge clk);
        funct3 = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4, res, lat, busy_n);
        check("busy_start_res", res, 32'hFFFF_FFEB);
        check("busy_start_lat", lat, LAT_NORM);
        count_done(45, pulses);
        check("busy_start_no_extra_done", pulses, 0);
        check("busy_start_idle", {31'd0, busy}, 32'd0);
        held = 32'hFFFF_FFEB;

        // kill at RUN counter=10: sampled at the 12th edge after the start edge
        launch(3'b101, 32'd100, 32'd7, 1'b0);
        repeat (11) @(negedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_busy_low", {31'd0, busy}, 32'd0);
        count_done(45, pulses);
        check("kill_no_done",    pulses, 0);
        check("kill_result_held", result, held);
        launch(3'b111, 32'd100, 32'd7, 1'b0);
        wait_done(0, res, lat, busy_n);
        check("after_kill_res", res, 32'd2);
        check("after_kill_lat", lat, LAT_NORM);

        // kill together with start in IDLE: start wins
        launch(3'b101, 32'd100, 32'd7, 1'b1);
        wait_done(0, res, lat, busy_n);
        check("kill_start_res", res, 32'd14);
        check("kill_start_lat", lat, LAT_NORM);

        // Asynchronous reset mid-RUN
        launch(3'b000, 32'h1234_5678, 32'h0000_0010, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, busy}, 32'd0);
        check("arst_done",   {31'd0, done}, 32'd0);
        check("arst_result", result,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(45, pulses);
        check("arst_no_done", pulses, 0);
        check("arst_idle",    {31'd0, busy}, 32'd0);
        launch(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
        wait_done(0, res, lat, busy_n);
        check("after_rst_res", res, 32'hFFFF_FFEB);
        check("after_rst_lat", lat, LAT_NORM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
